servo_pwm_drive: RTL and testbench



---
 rtl/servo_pwm_drive_if.sv | 33 +++
 rtl/servo_pwm_drive.sv | 125 ++++++++++++
 tb/tb_servo_pwm_drive.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/servo_pwm_drive_if.sv
// Step-enable inputs and PWM/position/limit outputs of servo_pwm_drive.
// master: tracker side driving steps; slave: the PWM drive itself.
interface servo_pwm_drive_if #(
  parameter int CNT_W = 21
);
  logic             SERVO_L;
  logic             SERVO_R;
  logic             SERVO_U;
  logic             SERVO_D;
  logic             PWM_H;
  logic             PWM_V;
  logic [CNT_W-1:0] POS_H;
  logic [CNT_W-1:0] POS_V;
  logic             LIM_L;
  logic             LIM_R;
  logic             LIM_U;
  logic             LIM_D;
  logic             FRAME_TICK;

  modport master (
    output SERVO_L, SERVO_R, SERVO_U, SERVO_D,
    input  PWM_H, PWM_V, POS_H, POS_V,
    input  LIM_L, LIM_R, LIM_U, LIM_D,
    input  FRAME_TICK
  );

  modport slave (
    input  SERVO_L, SERVO_R, SERVO_U, SERVO_D,
    output PWM_H, PWM_V, POS_H, POS_V,
    output LIM_L, LIM_R, LIM_U, LIM_D,
    output FRAME_TICK
  );
endinterface

// File: rtl/servo_pwm_drive.sv
// Two-axis hobby-servo PWM drive with saturating step positions.
// Ports: CLK, RST_N (async low), bus (slave): SERVO_* in; PWM/POS/LIM/TICK out.
module servo_pwm_drive #(
  parameter int PERIOD_CYC = 2000000,
  parameter int MIN_CYC    = 100000,
  parameter int MAX_CYC    = 200000,
  parameter int CENTER_CYC = 150000,
  parameter int STEP_CYC   = 1000,
  parameter int CNT_W      = 21
) (
  input  logic         CLK,
  input  logic         RST_N,
  servo_pwm_drive_if.slave bus
);

  localparam int W1 = CNT_W + 1;

  localparam logic [CNT_W-1:0] PER_M1 =
    CNT_W'(PERIOD_CYC - 1);
  localparam logic [CNT_W-1:0] CENTER =
    CNT_W'(CENTER_CYC);
  localparam logic [CNT_W-1:0] MIN_P =
    CNT_W'(MIN_CYC);
  localparam logic [CNT_W-1:0] MAX_P =
    CNT_W'(MAX_CYC);

  localparam logic [W1-1:0] MAX_W  = W1'(MAX_CYC);
  localparam logic [W1-1:0] STEP_W = W1'(STEP_CYC);
  // Below MIN+STEP a decrement would undershoot.
  localparam logic [W1-1:0] LO_TH  =
    W1'(MIN_CYC + STEP_CYC);

  logic             run_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pos_h_q, pos_h_d;
  logic [CNT_W-1:0] pos_v_q, pos_v_d;
  logic [CNT_W-1:0] shd_h_q, shd_h_d;
  logic [CNT_W-1:0] shd_v_q, shd_v_d;
  logic             pwm_h_q, pwm_h_d;
  logic             pwm_v_q, pwm_v_d;
  logic             tick;

  function automatic logic [CNT_W-1:0] step_up(
    input logic [CNT_W-1:0] p
  );
    logic [W1-1:0] s;
    s = {1'b0, p} + STEP_W;
    step_up = (s > MAX_W) ? MAX_P : s[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] step_dn(
    input logic [CNT_W-1:0] p
  );
    logic [W1-1:0] s;
    s = {1'b0, p} - STEP_W;
    if ({1'b0, p} < LO_TH) step_dn = MIN_P;
    else                   step_dn = s[CNT_W-1:0];
  endfunction

  // run_q keeps the counter parked at 0 until the
  // first edge after reset, which becomes frame cycle 0.
  assign tick = run_q && (cnt_q == PER_M1);

  always_comb begin
    cnt_d = '0;
    if (run_q && !tick) cnt_d = cnt_q + CNT_W'(1);

    pos_h_d = pos_h_q;
    pos_v_d = pos_v_q;
    if (tick) begin
      unique case ({bus.SERVO_L, bus.SERVO_R})
        2'b10:   pos_h_d = step_dn(pos_h_q);
        2'b01:   pos_h_d = step_up(pos_h_q);
        default: pos_h_d = pos_h_q;
      endcase
      unique case ({bus.SERVO_U, bus.SERVO_D})
        2'b10:   pos_v_d = step_up(pos_v_q);
        2'b01:   pos_v_d = step_dn(pos_v_q);
        default: pos_v_d = pos_v_q;
      endcase
    end

    // Widths only change at the frame boundary.
    shd_h_d = tick ? pos_h_d : shd_h_q;
    shd_v_d = tick ? pos_v_d : shd_v_q;

    // Registered PWM aligned to the counter value
    // it is loaded alongside.
    pwm_h_d = (cnt_d < shd_h_d);
    pwm_v_d = (cnt_d < shd_v_d);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      pos_h_q <= CENTER;
      pos_v_q <= CENTER;
      shd_h_q <= CENTER;
      shd_v_q <= CENTER;
      pwm_h_q <= 1'b0;
      pwm_v_q <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      cnt_q   <= cnt_d;
      pos_h_q <= pos_h_d;
      pos_v_q <= pos_v_d;
      shd_h_q <= shd_h_d;
      shd_v_q <= shd_v_d;
      pwm_h_q <= pwm_h_d;
      pwm_v_q <= pwm_v_d;
    end
  end

  assign bus.PWM_H      = pwm_h_q;
  assign bus.PWM_V      = pwm_v_q;
  assign bus.POS_H      = pos_h_q;
  assign bus.POS_V      = pos_v_q;
  assign bus.LIM_L      = (pos_h_q == MIN_P);
  assign bus.LIM_R      = (pos_h_q == MAX_P);
  assign bus.LIM_D      = (pos_v_q == MIN_P);
  assign bus.LIM_U      = (pos_v_q == MAX_P);
  assign bus.FRAME_TICK = tick;

endmodule

// File: tb/tb_servo_pwm_drive.sv
// Bench for servo_pwm_drive: directed frames, expected-frame queue,
// monitor pops one entry per FRAME_TICK and checks widths/pos/limits.
module tb_servo_pwm_drive;

  localparam int PER  = 100;
  localparam int MINC = 10;
  localparam int MAXC = 20;
  localparam int CEN  = 15;
  localparam int STP  = 3;
  localparam int W    = 8;

  typedef struct {
    int         h;
    int         v;
    logic [3:0] lim;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t q[$];

  servo_pwm_drive_if #(.CNT_W(W)) bus ();

  servo_pwm_drive #(
    .PERIOD_CYC (PER),
    .MIN_CYC    (MINC),
    .MAX_CYC    (MAXC),
    .CENTER_CYC (CEN),
    .STEP_CYC   (STP),
    .CNT_W      (W)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    assert (MINC <= CEN && CEN <= MAXC &&
            MAXC < PER && STP > 0)
      else $fatal(1, "bad bench parameters");
  end

  task automatic chk(input string nm,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Monitor state.
  int fc, hc, vc;
  bit hlow, vlow, glitch, rchk;

  always @(negedge clk) begin
    if (!rst_n) begin
      fc = 0; hc = 0; vc = 0;
      hlow = 0; vlow = 0; glitch = 0;
      if (!rchk) begin
        rchk = 1;
        chk("rst_pwm_h", int'(bus.PWM_H), 0);
        chk("rst_pwm_v", int'(bus.PWM_V), 0);
        chk("rst_pos_h", int'(bus.POS_H), CEN);
        chk("rst_pos_v", int'(bus.POS_V), CEN);
        chk("rst_tick", int'(bus.FRAME_TICK), 0);
        chk("rst_lim",
            int'({bus.LIM_L, bus.LIM_R,
                  bus.LIM_U, bus.LIM_D}), 0);
      end
    end else begin
      rchk = 0;
      if (bus.PWM_H) begin
        if (hlow) glitch = 1;
        hc++;
      end else hlow = 1;
      if (bus.PWM_V) begin
        if (vlow) glitch = 1;
        vc++;
      end else vlow = 1;
      if (bus.FRAME_TICK) begin
        if (q.size() == 0) begin
          chk("unexpected_tick", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("tick_cycle", fc, PER - 1);
          chk("width_h", hc, e.h);
          chk("width_v", vc, e.v);
          chk("pos_h", int'(bus.POS_H), e.h);
          chk("pos_v", int'(bus.POS_V), e.v);
          chk("lim_lrud",
              int'({bus.LIM_L, bus.LIM_R,
                    bus.LIM_U, bus.LIM_D}),
              int'(e.lim));
          chk("contiguous", int'(glitch), 0);
        end
        fc = 0; hc = 0; vc = 0;
        hlow = 0; vlow = 0; glitch = 0;
      end else begin
        fc++;
        if (fc > PER + 50) begin
          chk("tick_timeout", fc, PER - 1);
          fc = 0; hc = 0; vc = 0;
          hlow = 0; vlow = 0; glitch = 0;
        end
      end
    end
  end

  task automatic drive(input logic [3:0] en);
    bus.SERVO_L = en[3];
    bus.SERVO_R = en[2];
    bus.SERVO_U = en[1];
    bus.SERVO_D = en[0];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(4'b0000);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Starts just after the edge opening frame cycle 0
  // and returns at the same point of the next frame.
  // en = {L,R,U,D}; pulse_at<0 holds en all frame.
  task automatic run_frame(
    input logic [3:0] en,
    input int         pulse_at,
    input int         rst_at,
    input int         eh,
    input int         ev,
    input logic [3:0] el
  );
    exp_t e;
    if (rst_at < 0) begin
      e.h = eh; e.v = ev; e.lim = el;
      q.push_back(e);
    end
    for (int c = 0; c < PER; c++) begin
      if (rst_at == c) begin
        do_reset();
        return;
      end
      if (pulse_at < 0 || pulse_at == c) drive(en);
      else drive(4'b0000);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rchk     = 0;
    do_reset();

    // Idle, then R held three frames.
    run_frame(4'b0000, -1, -1, 15, 15, 4'b0000);
    run_frame(4'b0100, -1, -1, 15, 15, 4'b0000);
    run_frame(4'b0100, -1, -1, 18, 15, 4'b0000);
    run_frame(4'b0100, -1, -1, 20, 15, 4'b0100);
    run_frame(4'b0000, -1, -1, 20, 15, 4'b0100);
    run_frame(4'b0000, -1, 40,  0,  0, 4'b0000);

    // L held, then L+R.
    run_frame(4'b1000, -1, -1, 15, 15, 4'b0000);
    run_frame(4'b1000, -1, -1, 12, 15, 4'b0000);
    run_frame(4'b1000, -1, -1, 10, 15, 4'b1000);
    run_frame(4'b1100, -1, -1, 10, 15, 4'b1000);
    run_frame(4'b1100, -1, -1, 10, 15, 4'b1000);
    run_frame(4'b0000, -1, -1, 10, 15, 4'b1000);
    run_frame(4'b0000, -1,  5,  0,  0, 4'b0000);

    // Single-cycle U pulses off and on the tick.
    run_frame(4'b0010, 50, -1, 15, 15, 4'b0000);
    run_frame(4'b0010, 99, -1, 15, 15, 4'b0000);
    run_frame(4'b0000, -1, -1, 15, 18, 4'b0000);
    run_frame(4'b0000, -1, 60,  0,  0, 4'b0000);

    // L+U together, then D and U to the stops.
    run_frame(4'b1010, -1, -1, 15, 15, 4'b0000);
    run_frame(4'b0000, -1, -1, 12, 18, 4'b0000);
    run_frame(4'b0001, -1, -1, 12, 18, 4'b0000);
    run_frame(4'b0001, -1, -1, 12, 15, 4'b0000);
    run_frame(4'b0001, -1, -1, 12, 12, 4'b0000);
    run_frame(4'b0001, -1, -1, 12, 10, 4'b0001);
    run_frame(4'b0010, -1, -1, 12, 10, 4'b0001);
    run_frame(4'b0010, -1, -1, 12, 13, 4'b0000);
    run_frame(4'b0010, -1, -1, 12, 16, 4'b0000);
    run_frame(4'b0010, -1, -1, 12, 19, 4'b0000);
    run_frame(4'b0000, -1, -1, 12, 20, 4'b0010);

    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t limit 200000",
             $time);
    $fatal(1, "watchdog expired");
  end

endmodule
